// File: rtl/toggle_event_decoder_pkg.sv
// Shared types and defaults for the toggle-encoded event receiver.
// State encoding is visible on the state output, so it is fixed here.
package toggle_event_decoder_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_RUN  = 2'b10,
    ST_TOUT = 2'b11
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_PER_W       = 8;
  localparam int unsigned DEF_TIMEOUT     = 16;

endpackage

// File: rtl/toggle_event_decoder_sync.sv
// Multi-flop level synchroniser for a single asynchronous input bit.
// Reusable for any slow level crossing into the clk domain.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Receive side of a toggle-encoded event link: sync, edge decode,
// event counting, inter-event period and inactivity timeout.
module toggle_event_decoder
  import toggle_event_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned PER_W       = DEF_PER_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t_in,
  input  logic             clr,
  output logic             ev_pulse,
  output logic             ev_level,
  output logic [CNT_W-1:0] ev_count,
  output logic             ev_ovf,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic [1:0]       state
);

  localparam int unsigned INIT_W = $clog2(SYNC_STAGES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [PER_W-1:0]  GAP_MAX   = {PER_W{1'b1}};
  localparam logic [PER_W-1:0]  GAP_TOUT  = PER_W'(TIMEOUT - 1);

  logic s_out;
  logic trans;
  logic event_d;

  logic              prev_q;
  logic              pulse_q;
  state_e            state_q, state_d;
  logic [INIT_W-1:0] init_q, init_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic              pv_q, pv_d;
  logic [PER_W-1:0]  gap_q, gap_d;
  logic [PER_W-1:0]  gap_inc;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (t_in),
    .q_o   (s_out)
  );

  assign trans   = s_out ^ prev_q;
  assign event_d = trans && (state_q != ST_INIT);
  assign gap_inc = (gap_q == GAP_MAX) ? gap_q : gap_q + PER_W'(1);

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    per_d   = per_q;
    pv_d    = 1'b0;
    gap_d   = gap_q;

    unique case (state_q)
      ST_INIT: begin
        if (init_q == INIT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          init_d = init_q + INIT_W'(1);
        end
      end
      ST_IDLE: begin
        if (event_d) begin
          state_d = ST_RUN;
          gap_d   = '0;
        end
      end
      ST_RUN: begin
        if (event_d) begin
          per_d = gap_inc;
          pv_d  = 1'b1;
          gap_d = '0;
        end else begin
          gap_d = gap_inc;
          if (gap_q == GAP_TOUT) begin
            state_d = ST_TOUT;
          end
        end
      end
      ST_TOUT: begin
        // Period across a silent gap is meaningless, so no strobe here
        if (event_d) begin
          state_d = ST_RUN;
          gap_d   = '0;
        end else begin
          gap_d = gap_inc;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (event_d) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (clr && (state_q != ST_INIT)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      per_d   = '0;
      pv_d    = 1'b0;
      gap_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      state_q <= ST_INIT;
      init_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      per_q   <= '0;
      pv_q    <= 1'b0;
      gap_q   <= '0;
    end else begin
      prev_q  <= s_out;
      pulse_q <= event_d;
      state_q <= state_d;
      init_q  <= init_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      per_q   <= per_d;
      pv_q    <= pv_d;
      gap_q   <= gap_d;
    end
  end

  assign ev_pulse     = pulse_q;
  assign ev_level     = prev_q;
  assign ev_count     = cnt_q;
  assign ev_ovf       = ovf_q;
  assign period       = per_q;
  assign period_valid = pv_q;
  assign timeout      = (state_q == ST_TOUT);
  assign state        = state_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Scoreboard bench for toggle_event_decoder.
// Expected events are queued on each toggle and popped on ev_pulse.
module tb_toggle_event_decoder;

  logic       clk;
  logic       rst;
  logic       t_in;
  logic       clr;
  logic       ev_pulse;
  logic       ev_level;
  logic [7:0] ev_count;
  logic       ev_ovf;
  logic [7:0] period;
  logic       period_valid;
  logic       timeout;
  logic [1:0] state;

  typedef struct {
    logic       lvl;
    logic [7:0] cnt;
    logic       pv;
    logic [7:0] per;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_cnt  = 0;

  toggle_event_decoder #(
    .SYNC_STAGES (2),
    .CNT_W       (8),
    .PER_W       (8),
    .TIMEOUT     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .t_in         (t_in),
    .clr          (clr),
    .ev_pulse     (ev_pulse),
    .ev_level     (ev_level),
    .ev_count     (ev_count),
    .ev_ovf       (ev_ovf),
    .period       (period),
    .period_valid (period_valid),
    .timeout      (timeout),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at a negedge `spacing` cycles later.
  task automatic toggle_ev(input int spacing, input bit exp_pv,
                           input logic [7:0] exp_per);
    exp_t e;
    int   seen;
    t_in  = ~t_in;
    m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
    e.lvl = t_in;
    e.cnt = m_cnt[7:0];
    e.pv  = exp_pv;
    e.per = exp_per;
    sb_q.push_back(e);
    seen = 0;
    for (int i = 1; i <= spacing; i++) begin
      @(negedge clk);
      if (ev_pulse) begin
        seen++;
        checks++;
        if (i != 3) begin
          errors++;
          $display("FAIL latency: got %0d cycles want 3", i);
        end
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_pulse: got pulse want none");
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (ev_level !== e.lvl) begin
            errors++;
            $display("FAIL ev_level: got %0b want %0b", ev_level, e.lvl);
          end
          checks++;
          if (ev_count !== e.cnt) begin
            errors++;
            $display("FAIL ev_count: got %0d want %0d", ev_count, e.cnt);
          end
          checks++;
          if (period_valid !== e.pv) begin
            errors++;
            $display("FAIL period_valid: got %0b want %0b", period_valid, e.pv);
          end
          if (e.pv) begin
            checks++;
            if (period !== e.per) begin
              errors++;
              $display("FAIL period: got %0d want %0d", period, e.per);
            end
          end
        end
      end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL pulse_count: got %0d pulses want 1", seen);
      sb_q.delete();
    end
  endtask

  task automatic test_reset;
    int pulses;
    rst  = 1'b1;
    t_in = 1'b1;
    clr  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ev_pulse, ev_level, ev_count, ev_ovf, period, period_valid,
         timeout, state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero want all zero");
    end
    rst    = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (ev_pulse) pulses++;
      if (i == 2) begin
        checks++;
        if (state !== 2'b00) begin
          errors++;
          $display("FAIL init_hold: got %0d want 0", state);
        end
      end
    end
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL init_to_idle: got %0d want 1", state);
    end
    repeat (10) begin
      @(negedge clk);
      if (ev_pulse) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL no_spurious: got %0d pulses want 0", pulses);
    end
    checks++;
    if (ev_level !== 1'b1 || ev_count !== 8'd0) begin
      errors++;
      $display("FAIL idle_level_count: got %0b/%0d want 1/0", ev_level, ev_count);
    end
  endtask

  task automatic test_periodic;
    toggle_ev(10, 1'b0, 8'd0);
    repeat (3) toggle_ev(10, 1'b1, 8'd10);
    toggle_ev(3, 1'b1, 8'd10);
    checks++;
    if (ev_count !== 8'd5) begin
      errors++;
      $display("FAIL periodic_count: got %0d want 5", ev_count);
    end
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    while (!timeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16 || state !== 2'b11) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles state %0d want 16 state 3", n, state);
    end
    toggle_ev(10, 1'b0, 8'd0);
    checks++;
    if (timeout !== 1'b0 || state !== 2'b10 || ev_count !== 8'd6) begin
      errors++;
      $display("FAIL timeout_exit: got %0b/%0d/%0d want 0/2/6", timeout, state, ev_count);
    end
  endtask

  task automatic test_overflow;
    clr = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
    m_cnt = 0;
    checks++;
    if (ev_count !== 8'd0 || state !== 2'b01) begin
      errors++;
      $display("FAIL pre_clr: got %0d/%0d want 0/1", ev_count, state);
    end
    toggle_ev(4, 1'b0, 8'd0);
    repeat (256) toggle_ev(4, 1'b1, 8'd4);
    checks++;
    if (ev_count !== 8'd255 || ev_ovf !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got %0d/%0b want 255/1", ev_count, ev_ovf);
    end
    clr = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
    m_cnt = 0;
    checks++;
    if (ev_count !== 8'd0 || ev_ovf !== 1'b0 || period !== 8'd0 ||
        state !== 2'b01) begin
      errors++;
      $display("FAIL clr: got %0d/%0b/%0d/%0d want 0/0/0/1", ev_count, ev_ovf, period, state);
    end
  endtask

  task automatic test_clr_event;
    int n;
    t_in = ~t_in;
    n    = 0;
    while (!ev_pulse && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ev_pulse !== 1'b1 || ev_count !== 8'd1) begin
      errors++;
      $display("FAIL clr_pulse_seen: got %0b/%0d want 1/1", ev_pulse, ev_count);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (ev_count !== 8'd0 || state !== 2'b01) begin
      errors++;
      $display("FAIL clr_after_pulse: got %0d/%0d want 0/1", ev_count, state);
    end
    repeat (4) @(negedge clk);
    t_in = ~t_in;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (ev_pulse !== 1'b1 || ev_count !== 8'd0 || state !== 2'b01 ||
        period_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_coincident: got %0b/%0d/%0d/%0b want 1/0/1/0",
               ev_pulse, ev_count, state, period_valid);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset;
    int pulses;
    m_cnt = 0;
    toggle_ev(5, 1'b0, 8'd0);
    t_in = ~t_in;
    repeat (3) @(negedge clk);
    checks++;
    if (ev_pulse !== 1'b1 || state !== 2'b10) begin
      errors++;
      $display("FAIL pre_rst_run: got %0b/%0d want 1/2", ev_pulse, state);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ev_pulse, ev_level, ev_count, ev_ovf, period, period_valid,
         timeout, state} !== '0) begin
      errors++;
      $display("FAIL async_rst: got nonzero outputs want all zero");
    end
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (ev_pulse) pulses++;
      if (i == 2) begin
        checks++;
        if (state !== 2'b00) begin
          errors++;
          $display("FAIL rst_init: got %0d want 0", state);
        end
      end
    end
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL rst_idle: got %0d want 1", state);
    end
    repeat (8) begin
      @(negedge clk);
      if (ev_pulse) pulses++;
    end
    checks++;
    if (pulses != 0 || ev_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_no_spurious: got %0d pulses count %0d want 0/0", pulses, ev_count);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_timeout();
    test_overflow();
    test_clr_event();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
